// File: rtl/multi_interval_timer_if.sv
// Control/status bundle of the interval timer: requests in, countdown status out.
// The master modport drives the requests and the slave modport is the timer side.
interface multi_interval_timer_if #(
    parameter int SEC_W = 8
);
    logic             i_start;
    logic [SEC_W-1:0] i_load_val;
    logic             i_mode;
    logic             i_pause;
    logic             i_abort;
    logic [SEC_W-1:0] o_remain;
    logic             o_busy;
    logic             o_tick;
    logic             o_done;

    modport master (
        output i_start, i_load_val, i_mode, i_pause, i_abort,
        input  o_remain, o_busy, o_tick, o_done
    );

    modport slave (
        input  i_start, i_load_val, i_mode, i_pause, i_abort,
        output o_remain, o_busy, o_tick, o_done
    );
endinterface

// File: rtl/multi_interval_timer.sv
// Countdown interval timer: a prescaler makes base ticks and a down-counter runs a phase.
// The timer supports one-shot and periodic phases, pause with hold, abort and retrigger.
module multi_interval_timer #(
    parameter int PRESCALE = 50_000_000,
    parameter int SEC_W    = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    multi_interval_timer_if.slave bus
);
    localparam int PS_W = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    logic [PS_W-1:0]  r_presc;
    logic [SEC_W-1:0] r_remain;
    logic [SEC_W-1:0] r_reload;
    logic             r_mode;
    logic             r_busy;
    logic             r_tick;
    logic             r_done;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_presc  <= '0;
            r_remain <= '0;
            r_reload <= '0;
            r_mode   <= 1'b0;
            r_busy   <= 1'b0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here; later assignments in this block override.
            r_tick <= 1'b0;
            r_done <= 1'b0;

            if (bus.i_abort) begin
                r_state  <= ST_IDLE;
                r_presc  <= '0;
                r_remain <= '0;
                r_busy   <= 1'b0;
            end else if (bus.i_start) begin
                r_presc <= '0;
                if (bus.i_load_val != '0) begin
                    r_remain <= bus.i_load_val;
                    r_reload <= bus.i_load_val;
                    r_mode   <= bus.i_mode;
                    r_state  <= ST_RUN;
                    r_busy   <= 1'b1;
                end else begin
                    r_remain <= '0;
                    r_done   <= 1'b1;
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_RUN, ST_PAUSE: begin
                        if (bus.i_pause) begin
                            r_state <= ST_PAUSE;
                        end else begin
                            // The resume edge counts too, so a pause stretches the phase by its length exactly.
                            r_state <= ST_RUN;
                            if (r_presc == PS_MAX) begin
                                r_presc <= '0;
                                r_tick  <= 1'b1;
                                if (r_remain > SEC_W'(1)) begin
                                    r_remain <= r_remain - SEC_W'(1);
                                end else begin
                                    r_done <= 1'b1;
                                    if (r_mode) begin
                                        r_remain <= r_reload;
                                    end else begin
                                        r_remain <= '0;
                                        r_state  <= ST_IDLE;
                                        r_busy   <= 1'b0;
                                    end
                                end
                            end else begin
                                r_presc <= r_presc + PS_W'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.o_remain = r_remain;
    assign bus.o_busy   = r_busy;
    assign bus.o_tick   = r_tick;
    assign bus.o_done   = r_done;
endmodule

// File: tb/tb_multi_interval_timer.sv
// Directed bench for multi_interval_timer with PRESCALE=4, SEC_W=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_interval_timer;
    localparam int PRESCALE = 4;
    localparam int SEC_W    = 8;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multi_interval_timer_if #(.SEC_W(SEC_W)) bus ();

    multi_interval_timer #(
        .PRESCALE(PRESCALE),
        .SEC_W   (SEC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int remain, input bit busy,
                             input bit tick, input bit done);
        check({tag, ".remain"}, 32'(bus.o_remain), 32'(remain));
        check({tag, ".busy"},   32'(bus.o_busy),   32'(busy));
        check({tag, ".tick"},   32'(bus.o_tick),   32'(tick));
        check({tag, ".done"},   32'(bus.o_done),   32'(done));
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic start_phase(input int load, input bit mode);
        bus.i_start    = 1'b1;
        bus.i_load_val = SEC_W'(load);
        bus.i_mode     = mode;
        cyc();
        bus.i_start    = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        bus.i_start    = 1'b0;
        bus.i_load_val = '0;
        bus.i_mode     = 1'b0;
        bus.i_pause    = 1'b0;
        bus.i_abort    = 1'b0;

        // Reset state
        cyc();
        cyc();
        check_all("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc();
        check_all("post_reset", 0, 0, 0, 0);

        // One-shot, load 3: ticks 4/8/12 cycles after start, done with the third
        start_phase(3, 1'b0);
        check_all("os.start", 3, 1, 0, 0);
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check_all($sformatf("os.k%0d", k), 3 - k / 4, k < 12, (k % 4) == 0, k == 12);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check_all($sformatf("os.after%0d", k), 0, 0, 0, 0);
        end

        // Periodic, load 2: done every 8 cycles, remain 2,1,2,1...
        start_phase(2, 1'b1);
        check_all("per.start", 2, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            cyc();
            check_all($sformatf("per.k%0d", k), 2 - ((k / 4) % 2), 1, (k % 4) == 0, (k % 8) == 0);
        end
        bus.i_abort = 1'b1;
        cyc();
        bus.i_abort = 1'b0;
        check_all("per.abort", 0, 0, 0, 0);

        // Pause for 5 cycles at prescaler=2, remain=2: phase grows to 17 cycles
        start_phase(3, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc();
            check_all($sformatf("pz.k%0d", k), 3 - k / 4, 1, (k % 4) == 0, 0);
        end
        bus.i_pause = 1'b1;
        for (int k = 7; k <= 11; k++) begin
            cyc();
            check_all($sformatf("pz.hold%0d", k), 2, 1, 0, 0);
        end
        bus.i_pause = 1'b0;
        cyc();
        check_all("pz.k12", 2, 1, 0, 0);
        cyc();
        check_all("pz.k13", 1, 1, 1, 0);
        for (int k = 14; k <= 16; k++) begin
            cyc();
            check_all($sformatf("pz.k%0d", k), 1, 1, 0, 0);
        end
        cyc();
        check_all("pz.k17", 0, 0, 1, 1);

        // Retrigger: load 5, then load 2 at cycle 6; done 8 cycles later
        start_phase(5, 1'b0);
        for (int k = 1; k <= 5; k++) cyc();
        check_all("rt.k5", 4, 1, 0, 0);
        start_phase(2, 1'b0);
        check_all("rt.restart", 2, 1, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            check_all($sformatf("rt.k%0d", k), 2 - k / 4, k < 8, (k % 4) == 0, k == 8);
        end

        // Abort coinciding with the final wrap: no tick, no done
        start_phase(1, 1'b0);
        for (int k = 1; k <= 3; k++) cyc();
        check_all("ab.k3", 1, 1, 0, 0);
        bus.i_abort = 1'b1;
        cyc();
        bus.i_abort = 1'b0;
        check_all("ab.wrap", 0, 0, 0, 0);
        cyc();
        check_all("ab.after", 0, 0, 0, 0);

        // Start with load 0: single done pulse, never busy
        start_phase(0, 1'b0);
        check_all("z.pulse", 0, 0, 0, 1);
        cyc();
        check_all("z.after", 0, 0, 0, 0);

        // Asynchronous reset between clock edges, right after a tick
        start_phase(3, 1'b1);
        for (int k = 1; k <= 4; k++) cyc();
        check_all("ar.k4", 2, 1, 1, 0);
        #1 rst_n = 1'b0;
        #1 check_all("ar.async", 0, 0, 0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            check_all($sformatf("ar.idle%0d", k), 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multi_interval_timer.md
Name: multi_interval_timer

Overview:
- Parametrised countdown interval timer for the traffic-light controller, replacing fixed single-period tick blocks.
- A prescaler divides clk into base ticks (default 1 s at 50 MHz); a seconds down-counter runs a programmed phase length.
- Signals phase end and exposes the remaining count for the countdown display.
- Adds what fixed-period ticks lack: programmable length, one-shot or periodic mode, pause with hold, abort, and retrigger.

Parameters:
PRESCALE, 50_000_000, clk cycles per base tick; must be >= 2.
SEC_W, 8, width of load value and remaining counter.
PS_W, $clog2(PRESCALE), prescaler width (localparam, derived).

Ports:
clk  input  1  system clock, 50 MHz, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  load and run request, sampled each edge.
load_val  input  SEC_W  phase length in base ticks, sampled with start.
mode  input  1  0 = one-shot, 1 = periodic; sampled with start.
pause  input  1  level; holds prescaler and counter while high.
abort  input  1  level/pulse; returns to IDLE immediately.
remain  output  SEC_W  base ticks remaining in current phase.
busy  output  1  high in RUN or PAUSE.
tick  output  1  one-cycle pulse per completed base tick.
done  output  1  one-cycle pulse at phase end.

Behaviour:
- Reset (async, rst_n=0): state IDLE, prescaler 0, remain 0, reload reg 0, mode reg 0, busy 0, tick 0, done 0.
- All outputs are registered. tick and done default to 0 every cycle unless set below.
- Per-edge priority: abort > start > pause > count.
- States: IDLE, RUN, PAUSE.
- abort in any state:
  - next state IDLE; prescaler 0; remain 0.
  - No tick or done pulse, even if a wrap coincides.
- start, load_val != 0, any state (retrigger allowed):
  - remain <= load_val; reload reg <= load_val; mode reg <= mode; prescaler <= 0.
  - State RUN; busy 1 from the next cycle.
- start with load_val == 0:
  - done pulses next cycle; state IDLE; remain 0; no tick.
- RUN without pause, prescaler != PRESCALE-1: prescaler increments.
- RUN, prescaler == PRESCALE-1:
  - prescaler <= 0; tick <= 1.
  - If remain > 1: remain decrements.
  - If remain == 1 and mode reg = 0: remain <= 0; done <= 1; state IDLE; busy 0.
  - If remain == 1 and mode reg = 1: remain <= reload reg; done <= 1; stay RUN.
- Latency: first tick is asserted PRESCALE cycles after the edge that accepted start. done coincides with the final tick of the phase. Total one-shot length = load_val*PRESCALE cycles.
- pause high in RUN:
  - State PAUSE; prescaler and remain hold their values (not cleared).
  - pause wins over a coincident wrap: no tick that edge.
- PAUSE with pause low: state RUN; counting resumes from the held prescaler value, so the full tick period is preserved across the pause.
- pause in IDLE is ignored.
- start while PAUSE: restarts as above into RUN. If pause is still high, the next edge enters PAUSE.
- Counter arithmetic is unsigned. remain never wraps below 0. Prescaler never exceeds PRESCALE-1.
- Changes to mode or load_val without start have no effect on a running phase.
- Reset asserted mid-phase: all state clears asynchronously; no done pulse.

Test Plan:
- PRESCALE=4, SEC_W=8. Reset, then start with load_val=3, mode=0 → tick at 4, 8, 12 cycles after start; remain 3→2→1→0; done high with the third tick only; busy low after; no further ticks.
- mode=1, load_val=2 → done every 8 cycles; remain sequence 2,1,2,1…; busy stays 1 for 40 cycles.
- load_val=3, mode=0; pause high for 5 cycles when prescaler=2 and remain=2 → remain holds 2 and no tick during the pause; next tick 2 cycles after release; total phase = 12+5 cycles.
- Start load_val=5; at cycle 6 start again with load_val=2 → remain becomes 2; prescaler restarts; done occurs 8 cycles after the second start.
- abort asserted on the same edge as a wrap with remain=1 → no tick, no done; remain 0; busy 0. Also start with load_val=0 → single done pulse; busy stays 0.
- rst_n low asynchronously mid-phase (between clock edges) → all outputs 0 immediately; after release the block stays idle until start.
